// File: rtl/pipe_ctrl_if.sv
// Hazard-source and stage-control signal bundle between the pipeline datapath and pipe_ctrl.
// slave: the sequencer side; master: the datapath side that raises causes and consumes controls.
interface pipe_ctrl_if #(
   parameter int unsigned CNT_W = 32
);
   logic             if_busy;
   logic             mem_busy;
   logic             exc_valid;
   logic             ex_div;
   logic             ex_load;
   logic [4:0]       ex_regW;
   logic [4:0]       id_rs;
   logic [4:0]       id_rt;
   logic             id_use_rs;
   logic             id_use_rt;

   logic             pc_en;
   logic             pc_sel_exc;
   logic             ifid_en;
   logic             idex_en;
   logic             exmem_en;
   logic             memwb_en;
   logic             ifid_clr_n;
   logic             idex_clr_n;
   logic             exmem_clr_n;
   logic             memwb_clr_n;
   logic             div_busy;
   logic [CNT_W-1:0] stall_cnt;

   modport slave (
      input  if_busy, mem_busy, exc_valid, ex_div, ex_load, ex_regW,
             id_rs, id_rt, id_use_rs, id_use_rt,
      output pc_en, pc_sel_exc, ifid_en, idex_en, exmem_en, memwb_en,
             ifid_clr_n, idex_clr_n, exmem_clr_n, memwb_clr_n, div_busy, stall_cnt
   );

   modport master (
      output if_busy, mem_busy, exc_valid, ex_div, ex_load, ex_regW,
             id_rs, id_rt, id_use_rs, id_use_rt,
      input  pc_en, pc_sel_exc, ifid_en, idex_en, exmem_en, memwb_en,
             ifid_clr_n, idex_clr_n, exmem_clr_n, memwb_clr_n, div_busy, stall_cnt
   );
endinterface

// File: rtl/pipe_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: fixed-priority hazard resolution,
// divide-wait / exception-drain state machine and a stall-cycle performance counter.
module pipe_ctrl #(
   parameter int unsigned DIV_LAT = 32,
   parameter int unsigned CNT_W   = 32
) (
   input  logic       clk,
   input  logic       rset,
   pipe_ctrl_if.slave bus
);
   localparam int unsigned DCNT_W = 6;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      DIV      = 2'd1,
      EXC_WAIT = 2'd2
   } state_e;

   state_e              state_q, state_d;
   logic [DCNT_W-1:0]   div_cnt_q, div_cnt_d;
   logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;
   logic                load_use;
   logic                div_hold;

   assign load_use = bus.ex_load && (bus.ex_regW != 5'd0) &&
                     ((bus.id_use_rs && (bus.id_rs == bus.ex_regW)) ||
                      (bus.id_use_rt && (bus.id_rt == bus.ex_regW)));

   // Single-cycle decision; reset forces every control low asynchronously.
   always_comb begin
      state_d         = state_q;
      div_cnt_d       = div_cnt_q;
      div_hold        = 1'b0;
      bus.pc_en       = 1'b1;
      bus.pc_sel_exc  = 1'b0;
      bus.ifid_en     = 1'b1;
      bus.idex_en     = 1'b1;
      bus.exmem_en    = 1'b1;
      bus.memwb_en    = 1'b1;
      bus.ifid_clr_n  = 1'b1;
      bus.idex_clr_n  = 1'b1;
      bus.exmem_clr_n = 1'b1;
      bus.memwb_clr_n = 1'b1;
      bus.div_busy    = 1'b0;

      if (state_q == EXC_WAIT) begin
         // Stale fetch and younger stages stay flushed until the fetch returns.
         bus.ifid_clr_n  = 1'b0;
         bus.idex_clr_n  = 1'b0;
         bus.exmem_clr_n = 1'b0;
         bus.memwb_clr_n = 1'b0;
         if (!bus.if_busy) begin
            bus.pc_sel_exc = 1'b1;
            state_d        = RUN;
         end else begin
            bus.pc_en = 1'b0;
         end
      end else if (bus.exc_valid) begin
         bus.ifid_clr_n  = 1'b0;
         bus.idex_clr_n  = 1'b0;
         bus.exmem_clr_n = 1'b0;
         bus.memwb_clr_n = 1'b0;
         if (!bus.if_busy) begin
            bus.pc_sel_exc = 1'b1;
            state_d        = RUN;
         end else begin
            bus.pc_en = 1'b0;
            state_d   = EXC_WAIT;
         end
      end else if (state_q == DIV) begin
         if (div_cnt_q == '0) begin
            state_d = RUN;
         end else begin
            div_hold  = 1'b1;
            div_cnt_d = div_cnt_q - DCNT_W'(1);
         end
      end else if (bus.mem_busy) begin
         bus.pc_en       = 1'b0;
         bus.ifid_en     = 1'b0;
         bus.idex_en     = 1'b0;
         bus.exmem_en    = 1'b0;
         bus.memwb_clr_n = 1'b0;
      end else if (bus.ex_div) begin
         div_hold  = 1'b1;
         div_cnt_d = DCNT_W'(DIV_LAT - 1);
         state_d   = DIV;
      end else if (load_use) begin
         bus.pc_en      = 1'b0;
         bus.ifid_en    = 1'b0;
         bus.idex_clr_n = 1'b0;
      end else if (bus.if_busy) begin
         bus.pc_en      = 1'b0;
         bus.ifid_clr_n = 1'b0;
      end

      // Divide stays in EX; MEM receives bubbles while older work drains through WB.
      if (div_hold) begin
         bus.pc_en       = 1'b0;
         bus.ifid_en     = 1'b0;
         bus.idex_en     = 1'b0;
         bus.exmem_clr_n = 1'b0;
         bus.div_busy    = 1'b1;
      end

      if (!rset) begin
         state_d         = RUN;
         div_cnt_d       = '0;
         bus.pc_en       = 1'b0;
         bus.pc_sel_exc  = 1'b0;
         bus.ifid_en     = 1'b0;
         bus.idex_en     = 1'b0;
         bus.exmem_en    = 1'b0;
         bus.memwb_en    = 1'b0;
         bus.ifid_clr_n  = 1'b0;
         bus.idex_clr_n  = 1'b0;
         bus.exmem_clr_n = 1'b0;
         bus.memwb_clr_n = 1'b0;
         bus.div_busy    = 1'b0;
      end
   end

   assign stall_cnt_d   = bus.pc_en ? stall_cnt_q : stall_cnt_q + CNT_W'(1);
   assign bus.stall_cnt = stall_cnt_q;

   always_ff @(posedge clk or negedge rset) begin
      if (!rset) begin
         state_q     <= RUN;
         div_cnt_q   <= '0;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         div_cnt_q   <= div_cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end
endmodule

// File: tb/tb_pipe_ctrl.sv
// Randomized bench for pipe_ctrl against a cycle-level reference model of the stall/flush rules.
module tb_pipe_ctrl;
   localparam int unsigned DIV_LAT = 4;
   localparam int unsigned CNT_W   = 32;

   typedef struct packed {
      logic       if_busy;
      logic       mem_busy;
      logic       exc_valid;
      logic       ex_div;
      logic       ex_load;
      logic [4:0] ex_regW;
      logic [4:0] id_rs;
      logic [4:0] id_rt;
      logic       id_use_rs;
      logic       id_use_rt;
   } stim_t;

   logic clk;
   logic rset;
   int   checks;
   int   errors;

   // Reference model state: pending exception redirect, divide in flight and when it began.
   bit               exc_pending;
   bit               div_active;
   int               div_start;
   int               m_cycle;
   logic [CNT_W-1:0] m_stall;

   pipe_ctrl_if #(.CNT_W(CNT_W)) bus ();

   pipe_ctrl #(.DIV_LAT(DIV_LAT), .CNT_W(CNT_W)) dut (
      .clk  (clk),
      .rset (rset),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic stim_t idle();
      stim_t s;
      s = '0;
      return s;
   endfunction

   function automatic logic [10:0] dut_ctl();
      return {bus.pc_en, bus.pc_sel_exc, bus.ifid_en, bus.idex_en, bus.exmem_en, bus.memwb_en,
              bus.ifid_clr_n, bus.idex_clr_n, bus.exmem_clr_n, bus.memwb_clr_n, bus.div_busy};
   endfunction

   task automatic drive(input stim_t s);
      bus.if_busy   = s.if_busy;
      bus.mem_busy  = s.mem_busy;
      bus.exc_valid = s.exc_valid;
      bus.ex_div    = s.ex_div;
      bus.ex_load   = s.ex_load;
      bus.ex_regW   = s.ex_regW;
      bus.id_rs     = s.id_rs;
      bus.id_rt     = s.id_rt;
      bus.id_use_rs = s.id_use_rs;
      bus.id_use_rt = s.id_use_rt;
   endtask

   task automatic model_reset();
      exc_pending = 1'b0;
      div_active  = 1'b0;
      div_start   = 0;
      m_stall     = '0;
   endtask

   // One clock: drive, compare mid-cycle against the model, advance the model across the edge.
   task automatic step(input stim_t s);
      bit pc = 1, sel = 0, e1 = 1, e2 = 1, e3 = 1, e4 = 1;
      bit c1 = 1, c2 = 1, c3 = 1, c4 = 1, busy = 0, hold = 0;
      bit hazard;
      drive(s);
      @(negedge clk);
      hazard = s.ex_load && (s.ex_regW != 0) &&
               ((s.id_use_rs && s.id_rs == s.ex_regW) || (s.id_use_rt && s.id_rt == s.ex_regW));
      if (exc_pending) begin
         {c1, c2, c3, c4} = 4'b0000;
         if (!s.if_busy) begin sel = 1; exc_pending = 0; end
         else pc = 0;
      end else if (s.exc_valid) begin
         {c1, c2, c3, c4} = 4'b0000;
         div_active = 0;
         if (!s.if_busy) sel = 1;
         else begin pc = 0; exc_pending = 1; end
      end else if (div_active) begin
         if (m_cycle - div_start < int'(DIV_LAT)) hold = 1;
         else div_active = 0;
      end else if (s.mem_busy) begin
         pc = 0; e1 = 0; e2 = 0; e3 = 0; c4 = 0;
      end else if (s.ex_div) begin
         div_active = 1; div_start = m_cycle; hold = 1;
      end else if (hazard) begin
         pc = 0; e1 = 0; c2 = 0;
      end else if (s.if_busy) begin
         pc = 0; c1 = 0;
      end
      if (hold) begin
         pc = 0; e1 = 0; e2 = 0; c3 = 0; busy = 1;
      end
      chk("ctl", 64'(dut_ctl()), 64'({pc, sel, e1, e2, e3, e4, c1, c2, c3, c4, busy}));
      chk("stall_cnt", 64'(bus.stall_cnt), 64'(m_stall));
      if (!pc) m_stall = m_stall + CNT_W'(1);
      m_cycle++;
      @(posedge clk);
      #1;
   endtask

   function automatic stim_t rand_stim();
      stim_t s;
      s.if_busy   = ($urandom_range(3) == 0);
      s.mem_busy  = ($urandom_range(5) == 0);
      s.exc_valid = ($urandom_range(15) == 0);
      s.ex_div    = ($urandom_range(7) == 0);
      s.ex_load   = ($urandom_range(2) == 0);
      s.ex_regW   = 5'($urandom_range(3));
      s.id_rs     = 5'($urandom_range(3));
      s.id_rt     = 5'($urandom_range(3));
      s.id_use_rs = 1'($urandom_range(1));
      s.id_use_rt = 1'($urandom_range(1));
      return s;
   endfunction

   initial begin
      stim_t s;
      checks  = 0;
      errors  = 0;
      m_cycle = 0;
      model_reset();
      rset = 1'b0;
      drive(idle());
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_ctl", 64'(dut_ctl()), 64'(0));
      chk("reset_cnt", 64'(bus.stall_cnt), 64'(0));
      @(posedge clk);
      #1;
      rset = 1'b1;

      // Load-use on rs, then the same pattern with r0 which must not stall.
      s = idle(); s.ex_load = 1; s.ex_regW = 5; s.id_rs = 5; s.id_use_rs = 1;
      step(s);
      s.ex_regW = 0; s.id_rs = 0;
      step(s);
      step(idle());

      // Divide with quiet pipeline around it.
      s = idle(); s.ex_div = 1;
      step(s);
      repeat (DIV_LAT + 2) step(idle());

      // Three-cycle data wait.
      s = idle(); s.mem_busy = 1;
      repeat (3) step(s);
      step(idle());

      // Exception with no fetch outstanding.
      s = idle(); s.exc_valid = 1;
      step(s);
      step(idle());

      // Exception with fetch pending for two more cycles; divide request ignored meanwhile.
      s = idle(); s.exc_valid = 1; s.if_busy = 1;
      step(s);
      s.exc_valid = 0; s.ex_div = 1;
      repeat (2) step(s);
      s = idle(); s.ex_div = 1; s.exc_valid = 1;
      step(s);
      step(idle());

      // Exception aborts a divide in its second cycle.
      s = idle(); s.ex_div = 1;
      step(s);
      s = idle(); s.exc_valid = 1;
      step(s);
      repeat (2) step(idle());

      for (int i = 0; i < 1500; i++) step(rand_stim());

      // Asynchronous reset in the middle of a divide.
      s = idle(); s.ex_div = 1;
      step(s);
      step(idle());
      rset = 1'b0;
      #1;
      chk("async_rst_ctl", 64'(dut_ctl()), 64'(0));
      chk("async_rst_cnt", 64'(bus.stall_cnt), 64'(0));
      model_reset();
      @(posedge clk);
      #1;
      rset = 1'b1;
      repeat (3) step(idle());
      for (int i = 0; i < 200; i++) step(rand_stim());

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
